// File: rtl/btb_assoc_predictor_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// The entry struct depends on TAG_W, so it is declared inside the top module.
package btb_assoc_predictor_pkg;

    localparam int ADDR_W    = 32;
    localparam int CNT_MAX_W = 8;

    typedef struct packed {
        logic              hit;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } btb_pred_t;

    // Saturating direction counter step. The counter is zero-extended to
    // CNT_MAX_W so one function serves every CNT_W up to that width.
    function automatic logic [CNT_MAX_W-1:0] sat_update(
        input logic [CNT_MAX_W-1:0] cnt,
        input int unsigned          cnt_w,
        input logic                 taken
    );
        logic [CNT_MAX_W-1:0] max_v;
        max_v = CNT_MAX_W'((32'd1 << cnt_w) - 32'd1);
        if (taken)
            return (cnt >= max_v) ? max_v : cnt + 1'b1;
        else
            return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/btb_assoc_predictor_victim_sel.sv
// Allocation way choice for one set: lowest invalid way, else the round-robin
// pointer; alloc_is_evict flags that a valid entry is being replaced.
module btb_victim_sel #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] ptr,
    output logic [WAY_W-1:0] way,
    output logic             alloc_is_evict
);

    always_comb begin
        way            = ptr;
        alloc_is_evict = &valid;
        // Scan downwards so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w])
                way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/btb_assoc_predictor.sv
// Set-associative BTB with per-entry saturating direction counters.
// Combinational lookup for fetch; registered training, allocation and flush.
module btb_assoc_predictor
    import btb_assoc_predictor_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 2,
    parameter int PC_LSB = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] pc_fetch,
    output logic              hit,
    output logic              pred_outcome,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_btb,
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_outcome,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - PC_LSB - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CNT_W-1:0]  cnt;
    } btb_entry_t;

    btb_entry_t       tbl [SETS][WAYS];
    logic [WAY_W-1:0] ptr [SETS];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [WAYS-1:0]  f_match;
    btb_pred_t        f_pred;

    assign f_idx = pc_fetch[PC_LSB +: IDX_W];
    assign f_tag = pc_fetch[ADDR_W-1:PC_LSB+IDX_W];

    always_comb begin
        f_match = '0;
        f_pred  = '0;
        for (int w = 0; w < WAYS; w++) begin
            f_match[w] = tbl[f_idx][w].valid && (tbl[f_idx][w].tag == f_tag);
            if (f_match[w]) begin
                f_pred.target = f_pred.target | tbl[f_idx][w].target;
                f_pred.taken  = f_pred.taken | tbl[f_idx][w].cnt[CNT_W-1];
            end
        end
        f_pred.hit = |f_match;
    end

    assign hit          = f_pred.hit;
    assign pred_outcome = f_pred.taken;
    assign pred_target  = f_pred.target;

    // ---------------- training side ----------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic [WAYS-1:0]  u_valid;
    logic [WAYS-1:0]  u_match;
    logic             u_hit;
    logic [WAY_W-1:0] u_hit_way;
    logic [CNT_W-1:0] u_cnt;
    logic [CNT_W-1:0] u_cnt_next;
    logic [WAY_W-1:0] vic_way;
    logic             vic_evict;

    assign u_idx = pc[PC_LSB +: IDX_W];
    assign u_tag = pc[ADDR_W-1:PC_LSB+IDX_W];

    always_comb begin
        u_valid   = '0;
        u_match   = '0;
        u_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            u_valid[w] = tbl[u_idx][w].valid;
            u_match[w] = u_valid[w] && (tbl[u_idx][w].tag == u_tag);
            if (u_match[w])
                u_hit_way = WAY_W'(w);
        end
    end

    assign u_hit      = |u_match;
    assign u_cnt      = tbl[u_idx][u_hit_way].cnt;
    assign u_cnt_next = CNT_W'(sat_update(CNT_MAX_W'(u_cnt), CNT_W, branch_outcome));

    btb_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid          (u_valid),
        .ptr            (ptr[u_idx]),
        .way            (vic_way),
        .alloc_is_evict (vic_evict)
    );

    // Flush dominates a coincident update; counters and targets are left as-is.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    tbl[s][w] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    tbl[s][w].valid <= 1'b0;
            end
        end else if (update_btb) begin
            if (u_hit) begin
                tbl[u_idx][u_hit_way].cnt <= u_cnt_next;
                if (branch_outcome)
                    tbl[u_idx][u_hit_way].target <= branch_target;
            end else if (branch_outcome) begin
                tbl[u_idx][vic_way] <= '{valid: 1'b1, tag: u_tag,
                                         target: branch_target, cnt: CNT_INIT};
                // Single-way tables keep the pointer at zero so it folds away.
                if (vic_evict && (WAYS > 1))
                    ptr[u_idx] <= ptr[u_idx] + WAY_W'(1);
            end
        end
    end

    logic unused_lsb;
    assign unused_lsb = ^{pc_fetch[PC_LSB-1:0], pc[PC_LSB-1:0]};

    // Allocation only fires on a tag miss, so a tag can never occupy two ways.
    assert property (@(posedge CLK) disable iff (RST) $countones(f_match) <= 1)
        else $error("btb: multiple ways match pc_fetch");
    assert property (@(posedge CLK) disable iff (RST) $countones(u_match) <= 1)
        else $error("btb: multiple ways match update pc");

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Scoreboard bench for btb_assoc_predictor: the driver queues the expected
// lookup from an array-based reference model, a monitor compares each cycle.
module tb_btb_assoc_predictor;

    localparam int SETS   = 64;
    localparam int WAYS   = 2;
    localparam int CNT_W  = 2;
    localparam int PC_LSB = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int CNT_INIT = 1 << (CNT_W - 1);

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] pc_fetch = 32'h100;
    logic        hit;
    logic        pred_outcome;
    logic [31:0] pred_target;
    logic        update_btb = 1'b0;
    logic [31:0] pc = '0;
    logic        branch_outcome = 1'b0;
    logic [31:0] branch_target = '0;
    logic        flush = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    btb_assoc_predictor #(
        .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W), .PC_LSB(PC_LSB)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .pc_fetch       (pc_fetch),
        .hit            (hit),
        .pred_outcome   (pred_outcome),
        .pred_target    (pred_target),
        .update_btb     (update_btb),
        .pc             (pc),
        .branch_outcome (branch_outcome),
        .branch_target  (branch_target),
        .flush          (flush)
    );

    // ---------------- reference model ----------------
    bit          m_val [SETS][WAYS];
    int unsigned m_tag [SETS][WAYS];
    logic [31:0] m_tgt [SETS][WAYS];
    int          m_cnt [SETS][WAYS];
    int          m_ptr [SETS];

    function automatic int idx_of(input logic [31:0] p);
        return int'((p >> PC_LSB) % SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] p);
        return p / (SETS * (1 << PC_LSB));
    endfunction

    function automatic int find_way(input logic [31:0] p);
        for (int w = 0; w < WAYS; w++)
            if (m_val[idx_of(p)][w] && m_tag[idx_of(p)][w] == tag_of(p))
                return w;
        return -1;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_val[s][w] = 0;
        end
    endtask

    task automatic m_update(input logic [31:0] p, input logic tk, input logic [31:0] tg);
        int s, w;
        s = idx_of(p);
        w = find_way(p);
        if (w >= 0) begin
            m_cnt[s][w] = tk ? ((m_cnt[s][w] < CNT_MAX) ? m_cnt[s][w] + 1 : CNT_MAX)
                             : ((m_cnt[s][w] > 0) ? m_cnt[s][w] - 1 : 0);
            if (tk) m_tgt[s][w] = tg;
        end else if (tk) begin
            for (int k = WAYS - 1; k >= 0; k--)
                if (!m_val[s][k]) w = k;
            if (w < 0) begin
                w = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_val[s][w] = 1;
            m_tag[s][w] = tag_of(p);
            m_tgt[s][w] = tg;
            m_cnt[s][w] = CNT_INIT;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        pred;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] p,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s pc=%h actual=%h expected=%h t=%0t", name, p, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("hit",    mon_e.pc, 32'(hit),          32'(mon_e.hit));
            chk("pred",   mon_e.pc, 32'(pred_outcome), 32'(mon_e.pred));
            chk("target", mon_e.pc, pred_target,       mon_e.tgt);
        end
    end

    task automatic cyc(input logic [31:0] f, input logic upd, input logic [31:0] p,
                       input logic tk, input logic [31:0] tg, input logic fl);
        exp_t e;
        int   w;
        @(posedge CLK);
        #2;
        pc_fetch = f; update_btb = upd; pc = p;
        branch_outcome = tk; branch_target = tg; flush = fl;
        w     = find_way(f);
        e.pc  = f;
        e.hit = (w >= 0);
        e.pred = (w >= 0) && (m_cnt[idx_of(f)][w] >= CNT_INIT);
        e.tgt = (w >= 0) ? m_tgt[idx_of(f)][w] : 32'h0;
        q.push_back(e);
        if (fl) m_clear();
        else if (upd) m_update(p, tk, tg);
    endtask

    task automatic look(input logic [31:0] f);
        cyc(f, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] p, input logic tk, input logic [31:0] tg);
        cyc(p, 1'b1, p, tk, tg, 1'b0);
    endtask

    initial begin
        logic [31:0] rp, rf;
        m_clear();
        // reset state
        #1;
        chk("reset_hit",    pc_fetch, 32'(hit),          32'h0);
        chk("reset_pred",   pc_fetch, 32'(pred_outcome), 32'h0);
        chk("reset_target", pc_fetch, pred_target,       32'h0);
        #11 RST = 1'b0;

        look(32'h100);
        // train and saturate
        upd(32'h100, 1'b1, 32'h200);
        look(32'h100);
        repeat (2) upd(32'h100, 1'b1, 32'h200);
        look(32'h100);
        repeat (3) upd(32'h100, 1'b0, 32'h444);
        look(32'h100);
        upd(32'h100, 1'b0, 32'h444);
        look(32'h100);
        upd(32'h100, 1'b1, 32'h208);
        look(32'h100);

        // conflicts in set 0
        upd(32'h500, 1'b1, 32'h510);
        upd(32'h900, 1'b1, 32'h910);
        look(32'h100); look(32'h500); look(32'h900);
        upd(32'hD00, 1'b1, 32'hD10);
        look(32'h500); look(32'h900); look(32'hD00);

        // not-taken miss leaves set untouched
        upd(32'h300, 1'b0, 32'h999);
        look(32'h300);
        upd(32'h1100, 1'b1, 32'h1110);
        look(32'h900); look(32'hD00); look(32'h1100);

        // flush with coincident update, then same-cycle lookup/update
        cyc(32'h500, 1'b1, 32'h1500, 1'b1, 32'h1510, 1'b1);
        look(32'hD00); look(32'h1100); look(32'h1500);
        cyc(32'h600, 1'b1, 32'h600, 1'b1, 32'h660, 1'b0);
        look(32'h600);
        cyc(32'h600, 1'b1, 32'h600, 1'b1, 32'h670, 1'b0);
        look(32'h600);

        // randomized traffic over a few conflicting sets
        for (int i = 0; i < 500; i++) begin
            rp = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            rf = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            cyc(rf, 1'($urandom_range(0, 1)), rp, 1'($urandom_range(0, 1)),
                $urandom(), 1'($urandom_range(0, 49) == 0));
        end

        // async reset mid-training
        upd(32'h100, 1'b1, 32'h200);
        look(32'h100);
        @(posedge CLK);
        #2;
        pc_fetch = 32'h100; update_btb = 1'b1; pc = 32'h140;
        branch_outcome = 1'b1; branch_target = 32'h300; flush = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("rst_hit",    pc_fetch, 32'(hit),          32'h0);
        chk("rst_pred",   pc_fetch, 32'(pred_outcome), 32'h0);
        chk("rst_target", pc_fetch, pred_target,       32'h0);
        m_clear();
        update_btb = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        look(32'h100); look(32'h140);

        repeat (3) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
